muldiv_seq_ctrl: RTL and testbench
==================================

// Module: muldiv_seq_ctrl
// PURPOSE
//  Multi-cycle multiply/divide sequencer beside the single-cycle ALU in EX stage.
//  Runs MULT/MULTU/DIV/DIVU as an iterative shift-add / restoring-subtract FSM.
//  Writes HI/LO; busy stalls the pipeline while an operation is in flight.
// PARAMETERS
//  WIDTH     32   operand width; HI/LO each WIDTH bits
//  CNT_W     6    iteration counter width, >= clog2(WIDTH)+1
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      asynchronous active-low reset
//  start        in   1      launch request; sampled only in IDLE
//  op           in   2      00 MULTU, 01 DIVU, 10 MULT, 11 DIV
//  a            in   WIDTH  multiplicand / dividend
//  b            in   WIDTH  multiplier / divisor
//  flush        in   1      abort in-flight op (exception / branch flush)
//  busy         out  1      high from cycle after accepted start until done
//  done         out  1      1-cycle pulse; hi/lo valid same cycle
//  hi           out  WIDTH  MULT: upper product; DIV: remainder
//  lo           out  WIDTH  MULT: lower product; DIV: quotient
//  div_by_zero  out  1      set with done when DIV/DIVU had b==0; cleared on next accept
// BEHAVIOUR
//  Reset: state=IDLE, busy=0, done=0, hi=0, lo=0, div_by_zero=0, counter=0.
//  States: IDLE -> PREP -> CALC -> FIX -> DONE -> IDLE.
//   IDLE: start=1 & flush=0 -> latch a,b,op; PREP. Otherwise stay.
//   PREP (1 cyc): magnitudes (signed ops, see CONFIGURATION); count=WIDTH.
//    Divide with b==0 -> DONE directly (skip CALC/FIX).
//   CALC (WIDTH cyc): one bit per cycle; count-- ; count==1 -> FIX.
//    MUL: acc[2W-1:0]; if mult[0] acc_hi += mcand (W+1-bit carry kept); shift right 1.
//    DIV: rem = {rem[W-2:0],q[W-1]}; trial = rem - divisor (W+1 bits);
//    trial >= 0 -> rem=trial, q bit=1; else q bit=0.
//   FIX (1 cyc): apply result signs; register into hi/lo.
//   DONE (1 cyc): done=1, busy=0 combinationally off state; -> IDLE.
//  Latency: start cycle T -> done at T+WIDTH+3 (35 for WIDTH=32); div-by-zero at T+2.
//  Back-to-back: start may be asserted the cycle after done; next done T'+WIDTH+3.
//  busy=1 in PREP, CALC, FIX; 0 in IDLE and DONE.
//  start while busy: ignored, no queueing; requester must hold start until busy seen.
//  hi/lo: change only in FIX (or PREP div-by-zero path); stable otherwise, incl. idle.
//  Div by zero: hi=a (dividend, raw), lo={WIDTH{1'b1}}, div_by_zero=1 with done.
//  flush: any state -> IDLE next cycle; no done; hi/lo/div_by_zero keep prior values.
//   flush & start same cycle in IDLE: flush wins, op not accepted.
//   flush in DONE cycle: done still pulses this cycle (result already committed).
//  rst_n low mid-op: immediate return to reset values; no done.
// CONFIGURATION
//  MULDIV_SIGNED_EN defined: op[1]=1 signed. PREP takes |a|,|b|; FIX negates:
//   product if a[W-1]^b[W-1]; quotient if a^b sign; remainder takes sign of a.
//   DIV MIN/-1 (0x80000000/0xFFFFFFFF): lo=0x80000000, hi=0, no flag.
//  Not defined: op[1] ignored; MULT==MULTU, DIV==DIVU; no sign logic synthesised.
// TESTING
//  Reset: rst_n=0 mid-CALC -> busy=0, done=0, hi=lo=0 next cycle, no done later.
//  MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done @T+35, hi=0xFFFFFFFE lo=0x00000001.
//  DIVU a=100 b=7 -> lo=14 hi=2; DIVU a=5 b=0 -> done @T+2, lo=0xFFFFFFFF hi=5, div_by_zero=1.
//  MULTIV_SIGNED_EN: MULT a=-3 b=7 -> hi=0xFFFFFFFF lo=0xFFFFFFEB; DIV a=-7 b=2 -> lo=-3 hi=-1.
//  Without macro: MULT a=-3 b=7 -> hi=0x00000006 lo=0xFFFFFFEB (unsigned).
//  flush at CALC cycle 10 -> IDLE, no done, hi/lo unchanged; start during busy ignored;
//   start on cycle after done -> second result correct, done spacing 36 cycles.

Source files
------------

// File: rtl/muldiv_seq_ctrl.sv
// ---------------------------------------------------------------------------
// muldiv_seq_ctrl
//   Iterative multiply/divide sequencer that sits next to the single-cycle ALU
//   in the EX stage. It executes MULT/MULTU/DIV/DIVU as a shift-add multiplier
//   or a restoring divider, one result bit per cycle, and writes HI/LO.
//   busy holds the pipeline while an operation is in flight.
//
//   Sequence: IDLE -> PREP -> CALC (WIDTH cycles) -> FIX -> DONE -> IDLE.
//   A divide by zero goes PREP -> DONE with hi = raw dividend and lo = all ones.
//
// Configuration macro:
//   MULDIV_SIGNED_EN  when defined, op[1]=1 selects signed operation (operand
//                     magnitudes in PREP, result sign fix-up in FIX). When not
//                     defined, op[1] is ignored and no sign logic is built.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   start        in   launch request, sampled only in IDLE
//   op[1:0]      in   00 MULTU, 01 DIVU, 10 MULT, 11 DIV
//   a            in   multiplicand / dividend
//   b            in   multiplier / divisor
//   flush        in   abort any in-flight operation (returns to IDLE)
//   busy         out  high in PREP, CALC and FIX
//   done         out  one-cycle pulse in DONE; hi/lo valid that cycle
//   hi           out  MULT: upper product, DIV: remainder
//   lo           out  MULT: lower product, DIV: quotient
//   div_by_zero  out  set with done after a divide by zero, cleared on accept
// ---------------------------------------------------------------------------
module muldiv_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PREP = 3'd1;
    localparam logic [2:0] S_CALC = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]         state;
    logic [CNT_W-1:0]   count;

    // Operands captured at accept; they stay stable for the whole operation,
    // so sign information can be derived from them directly in FIX.
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic               is_div;

    // opnd holds the multiplicand (MUL) or divisor (DIV) magnitude.
    // acc is {hi_half, lo_half}: MUL {partial product, multiplier},
    // DIV {remainder, dividend shifting into quotient}.
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_step;

    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    logic               accept;
    logic               div_zero;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;

    assign accept   = (state == S_IDLE) && start && !flush;
    assign div_zero = is_div && (b_r == '0);

    assign busy = (state == S_PREP) || (state == S_CALC) || (state == S_FIX);
    assign done = (state == S_DONE);

`ifdef MULDIV_SIGNED_EN
    logic is_signed;
    logic neg_res;
    logic neg_rem;

    function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] v);
        return v[WIDTH-1] ? WIDTH'(-v) : WIDTH'(v);
    endfunction

    assign mag_a   = is_signed ? abs_val(a_r) : a_r;
    assign mag_b   = is_signed ? abs_val(b_r) : b_r;
    // Product and quotient are negative when operand signs differ;
    // the remainder follows the dividend.
    assign neg_res = is_signed && (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
    assign neg_rem = is_signed && a_r[WIDTH-1];

    always_comb begin
        res_hi = acc[2*WIDTH-1:WIDTH];
        res_lo = acc[WIDTH-1:0];
        if (is_div) begin
            if (neg_res) res_lo = -acc[WIDTH-1:0];
            if (neg_rem) res_hi = -acc[2*WIDTH-1:WIDTH];
        end else if (neg_res) begin
            {res_hi, res_lo} = -acc;
        end
    end
`else
    logic unused_sign;
    assign unused_sign = op[1];
    assign mag_a  = a_r;
    assign mag_b  = b_r;
    assign res_hi = acc[2*WIDTH-1:WIDTH];
    assign res_lo = acc[WIDTH-1:0];
`endif

    // One iteration of either algorithm. The divide trial is done on W+1 bits
    // so divisors with the top bit set are handled without losing the
    // remainder's shifted-out bit.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, opnd};
        div_diff  = WIDTH'(div_shift - {1'b0, opnd});
        if (is_div) begin
            if (div_ge) acc_step = {div_diff, acc[WIDTH-2:0], 1'b1};
            else        acc_step = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else begin
            acc_step = {mul_sum, acc[WIDTH-1:1]};
        end
    end

    // Datapath registers: no reset, they are always loaded before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_r    <= a;
            b_r    <= b;
            is_div <= op[0];
`ifdef MULDIV_SIGNED_EN
            is_signed <= op[1];
`endif
        end
        if (state == S_PREP) begin
            opnd <= is_div ? mag_b : mag_a;
            acc  <= {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
        end else if (state == S_CALC) begin
            acc <= acc_step;
        end
    end

    // Control FSM and architectural results. flush overrides every state;
    // in DONE the result is already committed so done still pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            count       <= '0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else if (flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state       <= S_PREP;
                        div_by_zero <= 1'b0;
                    end
                end
                S_PREP: begin
                    if (div_zero) begin
                        hi          <= a_r;
                        lo          <= '1;
                        div_by_zero <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        count <= CNT_W'(WIDTH);
                        state <= S_CALC;
                    end
                end
                S_CALC: begin
                    count <= count - 1'b1;
                    if (count == CNT_W'(1)) state <= S_FIX;
                end
                S_FIX: begin
                    hi    <= res_hi;
                    lo    <= res_lo;
                    state <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
module tb_muldiv_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;

    muldiv_seq_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          t;
        int          lat;
        int          id;
    } exp_t;

    vec_t vecs[14];
    exp_t exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] prev_hi = '0;
    logic [31:0] prev_lo = '0;
    logic        prev_dz = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Scoreboard: every done pops the oldest expected result.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1, want no done (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk($sformatf("op%0d_hi", e.id), hi, e.hi);
                chk($sformatf("op%0d_lo", e.id), lo, e.lo);
                chk($sformatf("op%0d_dz", e.id), 32'(div_by_zero), 32'(e.dz));
                chk($sformatf("op%0d_latency", e.id), 32'(cyc - e.t), 32'(e.lat));
            end
        end
    end

    // Drive one start pulse; the edge ending cycle t accepts it.
    task automatic issue(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                         input bit push, input logic [31:0] eh, input logic [31:0] el,
                         input logic ed, input int id, output int t);
        exp_t e;
        @(posedge clk); #1;
        start = 1'b1; op = o; a = av; b = bv;
        t = cyc;
        if (push) begin
            e.hi = eh; e.lo = el; e.dz = ed; e.t = t; e.lat = ed ? 2 : 35; e.id = id;
            exp_q.push_back(e);
            prev_hi = eh; prev_lo = el; prev_dz = ed;
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(negedge clk);
            seen = done;
        end
        chk("done_seen", 32'(seen), 32'd1);
        if (!seen) exp_q.delete();
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int t;
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00; a = '0; b = '0;

        // Unsigned vectors, identical in both builds.
        vecs[0] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[1] = '{2'b01, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
        vecs[2] = '{2'b01, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1};
        vecs[3] = '{2'b00, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};
        vecs[4] = '{2'b01, 32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 1'b0};
        vecs[5] = '{2'b01, 32'd7,        32'd100,      32'd7,        32'd0,        1'b0};
        vecs[6] = '{2'b00, 32'd0,        32'd5,        32'd0,        32'd0,        1'b0};
        vecs[7] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1,        32'd1,        1'b0};
        vecs[8] = '{2'b00, 32'h80000000, 32'd2,        32'd1,        32'd0,        1'b0};
        vecs[9] = '{2'b11, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1};
`ifdef MULDIV_SIGNED_EN
        vecs[10] = '{2'b10, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[11] = '{2'b11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[12] = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[13] = '{2'b11, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
`else
        vecs[10] = '{2'b10, 32'hFFFFFFFD, 32'd7,        32'h00000006, 32'hFFFFFFEB, 1'b0};
        vecs[11] = '{2'b11, 32'hFFFFFFF9, 32'd2,        32'd1,        32'h7FFFFFFC, 1'b0};
        vecs[12] = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0};
        vecs[13] = '{2'b11, 32'd7,        32'hFFFFFFFE, 32'd7,        32'd0,        1'b0};
`endif

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_dz", 32'(div_by_zero), 32'd0);
        rst_n = 1'b1;

        // Table vectors, issued back-to-back (start the cycle after done)
        for (int i = 0; i < 14; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1,
                  vecs[i].hi, vecs[i].lo, vecs[i].dz, i, t);
            chk($sformatf("op%0d_busy", i), 32'(busy), 32'd1);
            wait_done(60);
        end

        // start held while busy must be ignored
        issue(2'b00, 32'd3, 32'd5, 1'b1, 32'd0, 32'd15, 1'b0, 100, t);
        wait_cyc(t + 5);
        start = 1'b1; op = 2'b01; a = 32'd9; b = 32'd0;
        wait_cyc(t + 10);
        start = 1'b0;
        wait_done(60);
        repeat (40) @(posedge clk);
        #1;

        // flush at CALC cycle 10: no done, results untouched
        issue(2'b00, 32'hFFFFFFFF, 32'h2, 1'b0, '0, '0, 1'b0, 101, t);
        wait_cyc(t + 11);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy", 32'(busy), 32'd0);
        repeat (40) @(posedge clk);
        #1;
        chk("flush_hi", hi, prev_hi);
        chk("flush_lo", lo, prev_lo);
        chk("flush_dz", 32'(div_by_zero), 32'(prev_dz));

        // flush and start together in IDLE: flush wins
        @(posedge clk); #1;
        start = 1'b1; flush = 1'b1; op = 2'b01; a = 32'd1; b = 32'd0;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        chk("flush_start_busy", 32'(busy), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("flush_start_dz", 32'(div_by_zero), 32'(prev_dz));

        // flush in the DONE cycle: done still pulses with the result
        issue(2'b01, 32'd1000, 32'd9, 1'b1, 32'd1, 32'd111, 1'b0, 102, t);
        wait_cyc(t + 35);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_done_busy", 32'(busy), 32'd0);
        chk("flush_done_q", 32'(exp_q.size()), 32'd0);

        // reset mid-CALC
        issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, '0, '0, 1'b0, 103, t);
        wait_cyc(t + 12);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;

        // normal operation after reset
        issue(2'b01, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14, 1'b0, 104, t);
        wait_done(60);
        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
